// File: rtl/branch_perf_monitor.sv
// branch_perf_monitor: saturating event counters on the core's debug retire stream, read through a registered select port.
// Define BPM_TRACE_EN to build the mispredict-PC trace FIFO; without it the trace outputs are tied to zero.
module branch_perf_monitor #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_enable,
   input  logic                         i_clear,
   input  logic                         i_insn_vld,
   input  logic                         i_ctrl,
   input  logic                         i_mispred,
   input  logic [31:0]                  i_pc_debug,
   input  logic [1:0]                   i_rd_sel,
   output logic [CNT_W-1:0]             o_rd_data,
   output logic                         o_trace_vld,
   output logic [31:0]                  o_trace_pc,
   input  logic                         i_trace_rdy,
   output logic [$clog2(TRACE_DEPTH):0] o_trace_cnt,
   output logic                         o_trace_ovf
);
   localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [3:0]       ev;
   logic [CNT_W-1:0] cnt_q [4];

   // Event bits indexed like i_rd_sel: cycles, insns, ctrl, mispred
   always_comb begin
      ev[0] = i_enable;
      ev[1] = i_enable & i_insn_vld;
      ev[2] = i_enable & i_insn_vld & i_ctrl;
      ev[3] = i_enable & i_insn_vld & i_ctrl & i_mispred;
   end

   // Read port samples the pre-update value; counters stick at all-ones
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         o_rd_data <= '0;
      end else begin
         o_rd_data <= cnt_q[i_rd_sel];
         for (int i = 0; i < 4; i++) begin
            if (i_clear)
               cnt_q[i] <= '0;
            else if (ev[i] && (cnt_q[i] != '1))
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

`ifdef BPM_TRACE_EN
   logic [31:0]      mem [TRACE_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr_n;
   logic [OCC_W-1:0] rem;
   logic [OCC_W-1:0] occ_n;
   logic             pop;
   logic             full;
   logic             push;
   logic             drop;

   // A pop frees a slot for a same-edge push, so a full FIFO only drops when the head is not taken
   always_comb begin
      pop      = o_trace_vld & i_trace_rdy;
      full     = (o_trace_cnt == OCC_W'(TRACE_DEPTH));
      push     = ev[3] & (~full | pop);
      drop     = ev[3] & full & ~pop;
      rd_ptr_n = rd_ptr + PTR_W'(pop);
      rem      = o_trace_cnt - OCC_W'(pop);
      occ_n    = rem + OCC_W'(push);
   end

   always_ff @(posedge i_clk) begin
      if (push && !i_reset && !i_clear) mem[wr_ptr] <= i_pc_debug;
   end

   // Head register: the pushed PC when nothing older survives, else the next stored entry
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         o_trace_cnt <= '0;
         o_trace_vld <= 1'b0;
         o_trace_pc  <= '0;
         o_trace_ovf <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr      <= rd_ptr_n;
         o_trace_cnt <= occ_n;
         o_trace_vld <= (occ_n != '0);
         if (occ_n == '0)
            o_trace_pc <= '0;
         else if (rem == '0)
            o_trace_pc <= i_pc_debug;
         else
            o_trace_pc <= mem[rd_ptr_n];
         if (drop) o_trace_ovf <= 1'b1;
      end
   end
`else
   logic unused_trace;
   assign unused_trace = ^{i_trace_rdy, i_pc_debug};
   assign o_trace_vld  = 1'b0;
   assign o_trace_pc   = '0;
   assign o_trace_cnt  = '0;
   assign o_trace_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_perf_monitor.sv
// Bench for branch_perf_monitor: a 32-bit and a 4-bit counter instance share one directed stimulus stream,
// checked every cycle against a queue/integer model plus hand-computed literals.
module tb_branch_perf_monitor;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
`ifdef BPM_TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset, enable, clear, insn_vld, ctrl, mispred, trace_rdy;
   logic [31:0]       pc_debug;
   logic [1:0]        rd_sel;
   logic [31:0]       rd_data, tpc, tpc4;
   logic [3:0]        rd_data4;
   logic              tvld, tvld4, tovf, tovf4;
   logic [OCC_W-1:0]  tcnt, tcnt4;
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   branch_perf_monitor #(.CNT_W(32), .TRACE_DEPTH(DEPTH)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear(clear),
      .i_insn_vld(insn_vld), .i_ctrl(ctrl), .i_mispred(mispred), .i_pc_debug(pc_debug),
      .i_rd_sel(rd_sel), .o_rd_data(rd_data), .o_trace_vld(tvld), .o_trace_pc(tpc),
      .i_trace_rdy(trace_rdy), .o_trace_cnt(tcnt), .o_trace_ovf(tovf));

   branch_perf_monitor #(.CNT_W(4), .TRACE_DEPTH(DEPTH)) u_sat (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear(clear),
      .i_insn_vld(insn_vld), .i_ctrl(ctrl), .i_mispred(mispred), .i_pc_debug(pc_debug),
      .i_rd_sel(rd_sel), .o_rd_data(rd_data4), .o_trace_vld(tvld4), .o_trace_pc(tpc4),
      .i_trace_rdy(trace_rdy), .o_trace_cnt(tcnt4), .o_trace_ovf(tovf4));

   // Model: unbounded event tallies, a PC queue and a sticky drop flag
   longint unsigned m_cnt [4];
   logic [31:0]     m_q [$];
   bit              m_ovf;
   longint unsigned m_rd;
   bit              m_rd_known;
   bit              chk_en = 1'b0;

   function automatic longint unsigned sat(input longint unsigned v, input int w);
      longint unsigned mx;
      mx = (64'd1 << w) - 64'd1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      bit pop, full, mis;
      if (reset) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_q.delete();
         m_ovf = 1'b0; m_rd = 0; m_rd_known = 1'b1;
         return;
      end
      m_rd = m_cnt[rd_sel];
      m_rd_known = !clear;
      if (clear) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_q.delete();
         m_ovf = 1'b0;
         return;
      end
      mis = enable && insn_vld && ctrl && mispred;
      if (enable) begin
         m_cnt[0]++;
         if (insn_vld) begin
            m_cnt[1]++;
            if (ctrl) begin
               m_cnt[2]++;
               if (mispred) m_cnt[3]++;
            end
         end
      end
      if (TRACE) begin
         pop  = (m_q.size() != 0) && trace_rdy;
         full = (m_q.size() == DEPTH);
         if (pop) void'(m_q.pop_front());
         if (mis) begin
            if (!full || pop) m_q.push_back(pc_debug);
            else m_ovf = 1'b1;
         end
      end
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         if (m_rd_known) begin
            chk("rd_data", rd_data, sat(m_rd, 32));
            chk("rd_data_w4", rd_data4, sat(m_rd, 4));
         end
         chk("trace_vld", tvld, (m_q.size() != 0));
         chk("trace_vld_w4", tvld4, (m_q.size() != 0));
         chk("trace_cnt", tcnt, m_q.size());
         chk("trace_cnt_w4", tcnt4, m_q.size());
         chk("trace_ovf", tovf, m_ovf);
         chk("trace_ovf_w4", tovf4, m_ovf);
         if (m_q.size() != 0) begin
            chk("trace_pc", tpc, m_q[0]);
            chk("trace_pc_w4", tpc4, m_q[0]);
         end
      end
   end

   task automatic step(input bit v, input bit c, input bit m, input logic [31:0] pc, input bit rdy);
      insn_vld = v; ctrl = c; mispred = m; pc_debug = pc; trace_rdy = rdy;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] s, input string name, input longint unsigned e32,
                     input longint unsigned e4);
      rd_sel = s;
      idle();
      chk(name, rd_data, e32);
      chk({name, "_w4"}, rd_data4, e4);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; enable = 1'b1; rd_sel = 2'd0;
      insn_vld = 1'b0; ctrl = 1'b0; mispred = 1'b0; pc_debug = 32'h0; trace_rdy = 1'b0;
      repeat (3) idle();
      chk_en = 1'b1;
      chk("rst_rd", rd_data, 0);
      chk("rst_vld", tvld, 0);
      chk("rst_pc", tpc, 0);
      chk("rst_cnt", tcnt, 0);
      chk("rst_ovf", tovf, 0);
      reset = 1'b0;

      // Idle after reset: only the cycle counter moves
      repeat (10) idle();
      rd(2'd0, "cycles10", 10, 10);
      rd(2'd1, "insns0", 0, 0);
      rd(2'd2, "ctrl0", 0, 0);
      rd(2'd3, "mis0", 0, 0);

      // 20 retires, ctrl at 0,3,..,15, mispredicts at i=3 (0x40) and i=12 (0x88), then a stray mispredict
      for (int i = 0; i < 20; i++)
         step(1'b1, (i % 3 == 0) && (i < 18), (i == 3) || (i == 12),
              (i == 3) ? 32'h40 : (i == 12) ? 32'h88 : 32'h1000 + 32'(i * 4), 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'hdead, 1'b0);
      rd(2'd1, "insns20", 20, 15);
      rd(2'd2, "ctrl6", 6, 6);
      rd(2'd3, "mis2", 2, 2);
      chk("cnt2", tcnt, TRACE ? 2 : 0);
      chk("head_40", tpc, TRACE ? 32'h40 : 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("head_88", tpc, TRACE ? 32'h88 : 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("drained2", tvld, 0);

      // Ten mispredicts into a stalled FIFO: two dropped
      for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1, 32'h200 + 32'(k * 4), 1'b0);
      chk("full_cnt", tcnt, TRACE ? 8 : 0);
      chk("full_ovf", tovf, TRACE ? 1 : 0);
      for (int k = 0; k < 8; k++) begin
         chk("drain_first8", tpc, TRACE ? 32'h200 + 32'(k * 4) : 32'h0);
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      end
      chk("ovf_sticky", tovf, TRACE ? 1 : 0);

      // Clear wins over a same-cycle mispredict retire
      clear = 1'b1;
      step(1'b1, 1'b1, 1'b1, 32'h77, 1'b0);
      clear = 1'b0;
      chk("clr_ovf", tovf, 0);
      chk("clr_cnt", tcnt, 0);
      chk("clr_vld", tvld, 0);
      rd(2'd0, "clr_cyc", 0, 0);
      rd(2'd1, "clr_ins", 0, 0);
      rd(2'd2, "clr_ctl", 0, 0);
      rd(2'd3, "clr_mis", 0, 0);

      // Full FIFO with push and pop on the same edge
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, 32'h400 + 32'(k * 4), 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h500, 1'b1);
      chk("pp_cnt", tcnt, TRACE ? 8 : 0);
      chk("pp_ovf", tovf, 0);
      for (int k = 0; k < 8; k++) begin
         chk("pp_order", tpc, !TRACE ? 32'h0 : (k < 7) ? 32'h404 + 32'(k * 4) : 32'h500);
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      end

      // Five mispredicts after a clear, then a frozen one
      clear = 1'b1;
      idle();
      clear = 1'b0;
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 32'h600 + 32'(k * 4), 1'b0);
      rd(2'd3, "mis5", 5, 5);
      enable = 1'b0;
      step(1'b1, 1'b1, 1'b1, 32'h700, 1'b0);
      rd(2'd3, "mis_frozen", 5, 5);
      chk("frozen_cnt", tcnt, TRACE ? 5 : 0);
      enable = 1'b1;

      // Reset in the middle of a drain handshake
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      reset = 1'b0;
      chk("rst_drain_vld", tvld, 0);
      chk("rst_drain_cnt", tcnt, 0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
